// File: rtl/mod_pow_mult_seq_if.sv
// ---------------------------------------------------------------------------
// mod_pow_mult_seq_if
//   Start/busy/done bus between a sequencing controller (master) and the
//   modular A*x^B unit (slave).
//
//   Signals
//     start   master->slave  request, only looked at while the unit is idle
//     a       master->slave  coefficient A   (COEF_W)
//     b       master->slave  exponent B      (EXP_W)
//     x       master->slave  base x          (DATA_W)
//     busy    slave->master  high whenever the unit is not idle
//     done    slave->master  one-cycle pulse, result valid
//     result  slave->master  (A*x^B) mod MOD, held until the next done
//
//   Handshake: a request is accepted on the rising edge where start=1 and
//   busy=0; a/b/x are captured on that same edge and ignored afterwards.
//   Requests made while busy=1 (the done cycle included) are dropped, never
//   queued. Each accepted request produces exactly one done pulse unless a
//   reset aborts it, and busy drops in the cycle after done.
// ---------------------------------------------------------------------------
interface mod_pow_mult_seq_if #(
  parameter int DATA_W = 4,
  parameter int EXP_W  = 2,
  parameter int COEF_W = 2,
  parameter int RES_W  = 8
);
  logic              start;
  logic [COEF_W-1:0] a;
  logic [EXP_W-1:0]  b;
  logic [DATA_W-1:0] x;
  logic              busy;
  logic              done;
  logic [RES_W-1:0]  result;

  modport master (
    output start, a, b, x,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, x,
    output busy, done, result
  );
endinterface

// File: rtl/mod_pow_mult_seq.sv
// ---------------------------------------------------------------------------
// mod_pow_mult_seq
//   Sequential (A * x^B) mod MOD. One multiplier feeds a shift-subtract
//   reducer. The accumulator is reduced after every multiply, so the datapath
//   width depends only on RES_W and the operand width, never on B.
//
//   Operation: acc starts at 1; steps 0..B-1 multiply by x and step B
//   multiplies by A. Each step is one MUL cycle followed by K = W+1 RED
//   cycles, giving DONE entry (B+1)*(K+1) edges after the accepting edge.
//
//   Ports
//     clk          in   rising-edge clock
//     rst          in   synchronous, active-high reset (aborts any operation)
//     bus          slave side of mod_pow_mult_seq_if (start/a/b/x in,
//                  busy/done/result out)
//     o_dbg_state  out  current FSM state (0 IDLE, 1 MUL, 2 RED, 3 DONE)
// ---------------------------------------------------------------------------
module mod_pow_mult_seq #(
  parameter int DATA_W = 4,
  parameter int EXP_W  = 2,
  parameter int COEF_W = 2,
  parameter int RES_W  = 8,
  parameter int MOD    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_pow_mult_seq_if.slave    bus,
  output logic [1:0]           o_dbg_state
);

  // Operand width is the wider of x and A; one extra reducer bit per step.
  localparam int W   = (DATA_W > COEF_W) ? DATA_W : COEF_W;
  localparam int P_W = RES_W + W + 1;
  localparam int KW  = $clog2(W + 1);

  localparam logic [P_W-1:0] MOD_P = P_W'(MOD);
  localparam logic [KW-1:0]  K_TOP = KW'(W);

  // Modulus must fit the result and be at least 2.
  generate
    if (MOD < 2 || MOD > (2 ** RES_W) - 1) begin : g_bad_mod
      $error("mod_pow_mult_seq: MOD=%0d outside 2..2**RES_W-1", MOD);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RED  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [COEF_W-1:0] r_a;
  logic [EXP_W-1:0]  r_b;
  logic [DATA_W-1:0] r_x;
  logic [RES_W-1:0]  r_acc;
  logic [EXP_W-1:0]  r_step;
  logic [P_W-1:0]    r_p;
  logic [KW-1:0]     r_k;
  logic [RES_W-1:0]  r_result;

  logic              w_busy;
  logic              w_done;
  logic              w_last_step;
  logic              w_last_red;
  logic [W-1:0]      w_operand;
  logic [P_W-1:0]    w_prod;
  logic [P_W-1:0]    w_mod_shift;
  logic [P_W-1:0]    w_p_red;

  // -------------------------------------------------------------------------
  // Datapath combinational helpers
  // -------------------------------------------------------------------------
  assign w_last_step = (r_step == r_b);
  assign w_last_red  = (r_k == '0);

  // Steps before B use the base, the final step applies the coefficient.
  assign w_operand = (r_step < r_b) ? W'(r_x) : W'(r_a);

  // acc < MOD < 2**RES_W and operand < 2**W, so the product fits P_W bits.
  assign w_prod = P_W'(r_acc) * P_W'(w_operand);

  // One restoring-division step: p < MOD<<(k+1) on entry, p < MOD<<k after.
  assign w_mod_shift = MOD_P << r_k;
  assign w_p_red     = (r_p >= w_mod_shift) ? (r_p - w_mod_shift) : r_p;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_MUL;
        end
      end
      S_MUL: begin
        w_next_state = S_RED;
      end
      S_RED: begin
        if (w_last_red) begin
          w_next_state = w_last_step ? S_DONE : S_MUL;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (Moore)
  // -------------------------------------------------------------------------
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
      S_MUL, S_RED: begin
        w_busy = 1'b1;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_acc    <= '0;
      r_step   <= '0;
      r_p      <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands are captured only here, so later bus changes are inert.
          if (bus.start) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_x    <= bus.x;
            r_acc  <= RES_W'(1);
            r_step <= '0;
          end
        end
        S_MUL: begin
          r_p <= w_prod;
          r_k <= K_TOP;
        end
        S_RED: begin
          r_p <= w_p_red;
          if (!w_last_red) begin
            r_k <= r_k - 1'b1;
          end else begin
            // Final reducer cycle: value is now strictly below MOD.
            r_acc <= RES_W'(w_p_red);
            if (w_last_step) begin
              r_result <= RES_W'(w_p_red);
            end else begin
              r_step <= r_step + 1'b1;
            end
          end
        end
        default: begin
          // S_DONE holds everything; result stays valid until the next done.
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.result  = r_result;
  assign o_dbg_state = r_state;

endmodule
